// File: rtl/xge_tx_arb_pkg.sv
// Shared types and widths for the 10G MAC transmit arbiter.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package xge_tx_arb_pkg;

  localparam int XGE_DATA_W = 64;
  localparam int XGE_MOD_W  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // One beat of the MAC transmit packet interface.
  typedef struct packed {
    logic [XGE_DATA_W-1:0] data;
    logic [XGE_MOD_W-1:0]  mod;
    logic                  sop;
    logic                  eop;
  } pkt_beat_t;

endpackage

// File: rtl/xge_rr_picker.sv
// Round-robin picker: rotate requests past last_grant, take the lowest set bit, rotate back.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module xge_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               hit,
  output logic [ID_W-1:0]    idx
);

  // Two spare bits so start + position never wraps before the modulo fold.
  localparam int SUM_W = ID_W + 2;

  logic [SUM_W-1:0]   start;
  logic [NUM_REQ-1:0] rot;
  logic [SUM_W-1:0]   pos;
  logic [SUM_W-1:0]   sum;

  // Rotate so bit 0 is the requester right after the last winner, then priority-encode.
  always_comb begin
    start = SUM_W'(last_grant) + SUM_W'(1);
    if (start >= SUM_W'(NUM_REQ)) begin
      start = '0;
    end
    rot = NUM_REQ'({req, req} >> start);
    hit = |rot;
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = SUM_W'(k);
      end
    end
    sum = pos + start;
    if (sum >= SUM_W'(NUM_REQ)) begin
      sum = sum - SUM_W'(NUM_REQ);
    end
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-level round-robin arbiter muxing NUM_REQ sources onto the single MAC TX packet interface.
// Latency: accepted beat appears on pkt_tx_* one cycle later; one arbitration bubble per packet.
// Backpressure: pkt_tx_full drops the owner's req_rdy in the same cycle; one beat may still land after full.
module xge_tx_arbiter
  import xge_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk_156m25,
  input  logic                            reset_156m25_n,
  input  logic [NUM_REQ-1:0]              req_val,
  input  logic [NUM_REQ-1:0]              req_sop,
  input  logic [NUM_REQ-1:0]              req_eop,
  input  logic [XGE_MOD_W*NUM_REQ-1:0]    req_mod,
  input  logic [XGE_DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_rdy,
  input  logic                            pkt_tx_full,
  output logic                            pkt_tx_val,
  output logic                            pkt_tx_sop,
  output logic                            pkt_tx_eop,
  output logic [XGE_MOD_W-1:0]            pkt_tx_mod,
  output logic [XGE_DATA_W-1:0]           pkt_tx_data,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic                            drop_err
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]         state_q;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_q;
  pkt_beat_t          out_q;
  logic               out_val_q;
  logic               drop_q;

  logic [NUM_REQ-1:0] cand;
  logic               pick_hit;
  logic [ID_W-1:0]    pick_idx;
  pkt_beat_t          own_beat;
  logic               in_busy;
  logic               accept;
  logic               stray_drop;

  assign cand    = req_val & req_sop;
  assign in_busy = (state_q == ST_BUSY);

  xge_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req        (cand),
    .last_grant (last_q),
    .hit        (pick_hit),
    .idx        (pick_idx)
  );

  // Select the owner's beat; mod is only meaningful on the last beat of a frame.
  always_comb begin
    own_beat.data = req_data[XGE_DATA_W*grant_q +: XGE_DATA_W];
    own_beat.sop  = req_sop[grant_q];
    own_beat.eop  = req_eop[grant_q];
    own_beat.mod  = req_eop[grant_q] ? req_mod[XGE_MOD_W*grant_q +: XGE_MOD_W] : '0;
    accept        = in_busy & req_val[grant_q] & ~pkt_tx_full;
  end

  // Ready: owner follows full while busy; in idle, non-SOP beats are drained so a broken source cannot wedge us.
  always_comb begin
    req_rdy = '0;
    if (reset_156m25_n) begin
      if (in_busy) begin
        req_rdy[grant_q] = ~pkt_tx_full;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_rdy[i] = req_val[i] & ~req_sop[i] & ~(pick_hit && (pick_idx == ID_W'(i)));
        end
      end
    end
    stray_drop = ~in_busy & (|req_rdy);
  end

  // Arbitration FSM: grant on a SOP candidate, hold the bus until the owner's EOP is accepted.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_hit) begin
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            state_q <= ST_BUSY;
          end
        end
        default: begin
          if (accept && own_beat.eop) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Output register toward the MAC; idle cycles present an all-zero beat.
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      out_val_q <= 1'b0;
      out_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      out_val_q <= accept;
      out_q     <= accept ? own_beat : '0;
      drop_q    <= stray_drop;
    end
  end

  assign pkt_tx_val  = out_val_q;
  assign pkt_tx_sop  = out_q.sop;
  assign pkt_tx_eop  = out_q.eop;
  assign pkt_tx_mod  = out_q.mod;
  assign pkt_tx_data = out_q.data;
  assign grant_id    = grant_q;
  assign busy        = in_busy;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Bench for xge_tx_arbiter: directed vector table, round-robin order check, randomized traffic vs reference model.
// Latency: n/a.
// Backpressure: pkt_tx_full driven directly and randomly.
module tb_xge_tx_arbiter;

  localparam int N = 4;

  logic            clk_156m25;
  logic            reset_156m25_n;
  logic [N-1:0]    req_val;
  logic [N-1:0]    req_sop;
  logic [N-1:0]    req_eop;
  logic [3*N-1:0]  req_mod;
  logic [64*N-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            pkt_tx_full;
  logic            pkt_tx_val;
  logic            pkt_tx_sop;
  logic            pkt_tx_eop;
  logic [2:0]      pkt_tx_mod;
  logic [63:0]     pkt_tx_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            drop_err;

  xge_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .req_val        (req_val),
    .req_sop        (req_sop),
    .req_eop        (req_eop),
    .req_mod        (req_mod),
    .req_data       (req_data),
    .req_rdy        (req_rdy),
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_data    (pkt_tx_data),
    .grant_id       (grant_id),
    .busy           (busy),
    .drop_err       (drop_err)
  );

  initial clk_156m25 = 1'b0;
  always #5 clk_156m25 = ~clk_156m25;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic rst;
    logic [3:0] val, sop, eop;
    logic [2:0] mod;
    logic [63:0] data;
    logic full;
    logic [3:0] x_rdy;
    logic x_val, x_sop, x_eop;
    logic [2:0] x_mod;
    logic [63:0] x_data;
    logic [1:0] x_gid;
    logic x_busy, x_drop;
  } vec_t;

  typedef struct {
    logic sop, eop;
    logic [2:0] mod;
    logic [63:0] data;
  } beat_t;

  vec_t  tv[$];
  beat_t src_q[N][$];
  beat_t exp_q[N][$];
  int    m_owner, m_last, m_gid;
  int    sop_gid[$];
  int    sop_cyc[$];

  function automatic vec_t mkv(input logic rst, input logic [3:0] val, sop, eop, input logic [2:0] mod,
                               input logic [63:0] data, input logic full, input logic [3:0] x_rdy,
                               input logic x_val, x_sop, x_eop, input logic [2:0] x_mod,
                               input logic [63:0] x_data, input logic [1:0] x_gid,
                               input logic x_busy, x_drop);
    vec_t v;
    v.rst = rst; v.val = val; v.sop = sop; v.eop = eop; v.mod = mod; v.data = data; v.full = full;
    v.x_rdy = x_rdy; v.x_val = x_val; v.x_sop = x_sop; v.x_eop = x_eop; v.x_mod = x_mod;
    v.x_data = x_data; v.x_gid = x_gid; v.x_busy = x_busy; v.x_drop = x_drop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_156m25_n = 1'b0;
    req_val = '0; req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0; pkt_tx_full = 1'b0;
    repeat (2) @(negedge clk_156m25);
    reset_156m25_n = 1'b1;
    m_owner = -1; m_last = N - 1; m_gid = 0;
  endtask

  // Cycle-level reference: owner index or -1, round-robin search by modulo walk, scoreboard per requester.
  task automatic run_engine(input bit rnd, input int budget);
    logic [N-1:0] exp_rdy;
    int pick, c;
    bit done, e_val, e_drop, release_bus;
    beat_t b, eb;
    for (int cyc = 0; cyc < budget; cyc++) begin
      done = 1'b1;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
      if (done) break;
      for (int i = 0; i < N; i++) begin
        req_val[i] = (src_q[i].size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
        if (src_q[i].size() != 0) begin
          b = src_q[i][0];
          req_sop[i] = b.sop; req_eop[i] = b.eop;
          req_mod[3*i +: 3] = b.mod; req_data[64*i +: 64] = b.data;
        end else begin
          req_sop[i] = 1'b0; req_eop[i] = 1'b0;
          req_mod[3*i +: 3] = 3'd0; req_data[64*i +: 64] = 64'd0;
        end
      end
      pkt_tx_full = rnd && ($urandom_range(0, 4) == 0);
      #1;
      exp_rdy = '0;
      pick = -1;
      if (m_owner >= 0) begin
        exp_rdy[m_owner] = !pkt_tx_full;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (pick < 0 && req_val[c] && req_sop[c]) pick = c;
        end
        for (int i = 0; i < N; i++) if (req_val[i] && !req_sop[i]) exp_rdy[i] = 1'b1;
      end
      chk($sformatf("eng rdy c%0d", cyc), 64'(req_rdy), 64'(exp_rdy));
      e_val = 1'b0; e_drop = 1'b0; release_bus = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req_val[i] && exp_rdy[i]) begin
          b = src_q[i].pop_front();
          if (m_owner == i) begin
            e_val = 1'b1;
            if (b.eop) release_bus = 1'b1;
          end else begin
            e_drop = 1'b1;
          end
        end
      end
      if (release_bus) m_owner = -1;
      if (pick >= 0) begin
        m_owner = pick; m_last = pick; m_gid = pick;
      end
      @(negedge clk_156m25);
      chk($sformatf("eng val c%0d", cyc), 64'(pkt_tx_val), 64'(e_val));
      chk($sformatf("eng gid c%0d", cyc), 64'(grant_id), 64'(m_gid));
      chk($sformatf("eng busy c%0d", cyc), 64'(busy), 64'(m_owner >= 0));
      chk($sformatf("eng drop c%0d", cyc), 64'(drop_err), 64'(e_drop));
      if (pkt_tx_val) begin
        if (exp_q[m_gid].size() == 0) begin
          chk($sformatf("eng extra beat c%0d", cyc), 64'd1, 64'd0);
        end else begin
          eb = exp_q[m_gid].pop_front();
          chk($sformatf("eng data c%0d", cyc), pkt_tx_data, eb.data);
          chk($sformatf("eng ctl c%0d", cyc), 64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
              64'({eb.sop, eb.eop, eb.mod}));
        end
        if (pkt_tx_sop) begin
          sop_gid.push_back(int'(grant_id));
          sop_cyc.push_back(cyc);
        end
      end
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("eng drained r%0d", i), 64'(src_q[i].size() + exp_q[i].size()), 64'd0);
  endtask

  task automatic push_pkt(input int r, input int len, input bit allow_stray);
    beat_t b, e;
    if (allow_stray && $urandom_range(0, 7) == 0) begin
      b.sop = 1'b0; b.eop = 1'($urandom_range(0, 1)); b.mod = 3'($urandom); b.data = {$urandom, $urandom};
      src_q[r].push_back(b);
    end
    for (int j = 0; j < len; j++) begin
      b.sop = (j == 0); b.eop = (j == len - 1);
      b.mod = 3'($urandom); b.data = {$urandom, $urandom};
      src_q[r].push_back(b);
      e = b;
      if (!e.eop) e.mod = 3'd0;
      exp_q[r].push_back(e);
    end
  endtask

  initial begin
    // rst, val, sop, eop, mod, data, full | rdy, val, sop, eop, mod, data, gid, busy, drop
    // reset with strays present
    tv.push_back(mkv(1'b0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 64'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b0, 1'b0));
    // requester 0, 3-beat packet
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0001, 4'b0000, 3'd0, 64'h11, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0001, 4'b0000, 3'd0, 64'h11, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd0, 64'h11, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0000, 4'b0000, 3'd3, 64'h22, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 64'h22, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd5, 64'h33, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 3'd5, 64'h33, 2'd0, 1'b0, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b0, 1'b0));
    // requester 1 with full held 4 cycles, then full on the EOP cycle
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0010, 4'b0000, 3'd0, 64'hA1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0110, 4'b0110, 4'b0000, 3'd0, 64'hA1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA1, 2'd1, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++)
      tv.push_back(mkv(1'b1, 4'b0010, 4'b0000, 4'b0000, 3'd6, 64'hA2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0000, 4'b0000, 3'd6, 64'hA2, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 3'd0, 64'hA2, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0000, 4'b0010, 3'd2, 64'hA3, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0000, 4'b0010, 3'd2, 64'hA3, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 3'd2, 64'hA3, 2'd1, 1'b0, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b0, 1'b0));
    // stray beat from requester 2 while idle
    tv.push_back(mkv(1'b1, 4'b0100, 4'b0000, 4'b0000, 3'd0, 64'hDEAD, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b0, 1'b1));
    tv.push_back(mkv(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, 64'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b0, 1'b0));
    // stray from 2 in the same cycle requester 0 is granted
    tv.push_back(mkv(1'b1, 4'b0101, 4'b0001, 4'b0000, 3'd4, 64'h55, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b1, 1'b1));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0001, 4'b0001, 3'd4, 64'h55, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 3'd4, 64'h55, 2'd0, 1'b0, 1'b0));
    // single-beat packet from 3, then 2-beat packet from 0
    tv.push_back(mkv(1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd0, 64'h03, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd3, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd0, 64'h03, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 3'd0, 64'h03, 2'd3, 1'b0, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0001, 4'b0000, 3'd0, 64'h0A, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0001, 4'b0000, 3'd0, 64'h0A, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0A, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0001, 4'b0000, 4'b0001, 3'd1, 64'h0B, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 3'd1, 64'h0B, 2'd0, 1'b0, 1'b0));
    // reset in the middle of a packet from requester 1; afterwards 0 beats 1
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0010, 4'b0000, 3'd0, 64'hB1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0010, 4'b0000, 3'd0, 64'hB1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 3'd0, 64'hB1, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b0, 4'b0010, 4'b0000, 4'b0000, 3'd0, 64'hB2, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b0, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0011, 4'b0011, 4'b0000, 3'd0, 64'hC1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd0, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0011, 4'b0011, 4'b0001, 3'd0, 64'hC1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 3'd0, 64'hC1, 2'd0, 1'b0, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0010, 4'b0000, 3'd0, 64'hD1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'd1, 1'b1, 1'b0));
    tv.push_back(mkv(1'b1, 4'b0010, 4'b0010, 4'b0010, 3'd7, 64'hD1, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 3'd7, 64'hD1, 2'd1, 1'b0, 1'b0));

    do_reset();
    foreach (tv[k]) begin
      reset_156m25_n = tv[k].rst;
      req_val = tv[k].val; req_sop = tv[k].sop; req_eop = tv[k].eop;
      req_mod = {N{tv[k].mod}}; req_data = {N{tv[k].data}}; pkt_tx_full = tv[k].full;
      #1;
      chk($sformatf("v%0d rdy", k), 64'(req_rdy), 64'(tv[k].x_rdy));
      @(negedge clk_156m25);
      chk($sformatf("v%0d val", k), 64'(pkt_tx_val), 64'(tv[k].x_val));
      chk($sformatf("v%0d sop", k), 64'(pkt_tx_sop), 64'(tv[k].x_sop));
      chk($sformatf("v%0d eop", k), 64'(pkt_tx_eop), 64'(tv[k].x_eop));
      chk($sformatf("v%0d mod", k), 64'(pkt_tx_mod), 64'(tv[k].x_mod));
      chk($sformatf("v%0d data", k), pkt_tx_data, tv[k].x_data);
      chk($sformatf("v%0d gid", k), 64'(grant_id), 64'(tv[k].x_gid));
      chk($sformatf("v%0d busy", k), 64'(busy), 64'(tv[k].x_busy));
      chk($sformatf("v%0d drop", k), 64'(drop_err), 64'(tv[k].x_drop));
    end

    // All four requesters with 2-beat packets, plus a second one from 0.
    do_reset();
    for (int r = 0; r < N; r++) push_pkt(r, 2, 1'b0);
    push_pkt(0, 2, 1'b0);
    sop_gid.delete(); sop_cyc.delete();
    run_engine(1'b0, 100);
    chk("rr sop count", 64'(sop_gid.size()), 64'd5);
    if (sop_gid.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr order %0d", k), 64'(sop_gid[k]), 64'(k % N));
        if (k > 0) chk($sformatf("rr spacing %0d", k), 64'(sop_cyc[k] - sop_cyc[k-1]), 64'd3);
      end
    end

    // Randomized traffic with stalls, full and stray beats.
    do_reset();
    for (int r = 0; r < N; r++) begin
      int np = $urandom_range(3, 8);
      for (int p = 0; p < np; p++) push_pkt(r, $urandom_range(1, 4), 1'b1);
    end
    run_engine(1'b1, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
